serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
//  Computes a + ~b + 1 through a single 1-bit full-adder slice and a carry flip-flop.
//  Sequential counterpart to the ripple-carry adder datapath, for area-constrained ALU paths.
//  Results keep the adder's flag conventions: carryout = 1 means no borrow; overflow = signed overflow.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>= 2)
// PORTS
//  clk         in   1      single clock; all state changes on the rising edge
//  reset_n     in   1      synchronous, active-low reset
//  start       in   1      request: sample a/b and begin; accepted only in IDLE or DONE
//  a           in   WIDTH  minuend, two's complement
//  b           in   WIDTH  subtrahend, two's complement
//  busy        out  1      high while in SHIFT
//  done        out  1      one-cycle pulse: result outputs just updated
//  difference  out  WIDTH  a - b modulo 2^WIDTH
//  carryout    out  1      carry out of MSB of a + ~b + 1 (1 = a >= b unsigned)
//  overflow    out  1      carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=IDLE; busy, done, difference, carryout, overflow all 0.
//   Counter, carry and shift registers are cleared. Reset during SHIFT aborts with no done.
//  FSM: IDLE -> SHIFT on start. SHIFT -> DONE after WIDTH bit-edges. DONE -> SHIFT on start.
//   DONE -> IDLE when start=0. Only reset leaves SHIFT early.
//  Accept edge (start=1 in IDLE/DONE):
//   a_sh<=a; nb_sh<=~b; c<=1; cnt<=0; state<=SHIFT.
//  SHIFT edge i (i = 0..WIDTH-1), i.e. edges 1..WIDTH after accept:
//   s = a_sh[0]^nb_sh[0]^c; c <= a_sh[0]&nb_sh[0] | (a_sh[0]^nb_sh[0])&c.
//   Shift s into d_sh MSB, shift a_sh/nb_sh right, cnt++.
//   At i = WIDTH-1, also capture the MSB carry-in (current c) for overflow.
//  DONE entry (same edge as the last SHIFT bit):
//   difference <= final d_sh (including bit WIDTH-1), carryout <= final carry,
//   overflow <= msb_cin ^ final carry.
//   done=1 for exactly that cycle, i.e. WIDTH+1 edges after the accept edge.
//  difference/carryout/overflow change only on DONE entry.
//   They hold their previous values through IDLE and SHIFT.
//  start while busy=1 is ignored (no restart, no queueing). a and b are don't-care except on the accept edge.
//  Back-to-back: start=1 during the done cycle is accepted. busy rises next cycle.
//   Throughput is one result per WIDTH+1 cycles.
//  a = b gives difference 0, carryout 1, overflow 0. Most negative minus a positive value overflows.
// TESTING (WIDTH=4; results checked on the done cycle)
//  5-3: a=0101 b=0011 -> difference=0010, carryout=1, overflow=0, done 5 edges after accept.
//  3-5: a=0011 b=0101 -> difference=1110, carryout=0, overflow=0.
//  7-(-1): a=0111 b=1111 -> difference=1000, carryout=0, overflow=1.
//   -8-1:  a=1000 b=0001 -> difference=0111, carryout=1, overflow=1.
//  Busy/back-to-back: start 0-0, re-pulse start during busy with a=1 b=1 -> ignored.
//   Result is 0000/c=1/o=0. Hold start in the done cycle with a=2 b=1 -> next result 0001.
//  Reset mid-op: start 5-3, drop reset_n for 1 edge after 2 SHIFT edges.
//   -> all outputs 0, state IDLE, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor (a - b, LSB first)
//
// Computes a + ~b + 1 one bit per clock through a single full-adder slice
// and a carry flip-flop. Result flags follow the ripple adder conventions.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous active-low reset
//   start      in   1      sample a/b and begin; honoured only in IDLE or DONE
//   a          in   WIDTH  minuend (two's complement)
//   b          in   WIDTH  subtrahend (two's complement)
//   busy       out  1      high while bits are being shifted
//   done       out  1      one-cycle pulse, result outputs just updated
//   difference out  WIDTH  a - b modulo 2^WIDTH
//   carryout   out  1      carry out of MSB (1 = no borrow, a >= b unsigned)
//   overflow   out  1      signed overflow (MSB carry-in ^ MSB carry-out)

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             carryout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_nb_sh;
    logic [WIDTH-1:0] r_d_sh;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_d_next;

    // Single full-adder slice on the current LSBs.
    assign w_sum    = r_a_sh[0] ^ r_nb_sh[0] ^ r_c;
    assign w_carry  = (r_a_sh[0] & r_nb_sh[0]) | ((r_a_sh[0] ^ r_nb_sh[0]) & r_c);
    assign w_d_next = {w_sum, r_d_sh[WIDTH-1:1]};
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept = start && (r_state != S_SHIFT);

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = start ? S_SHIFT : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_sh  <= '0;
            r_nb_sh <= '0;
            r_d_sh  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Carry-in of 1 completes the two's-complement negation of b.
            r_a_sh  <= a;
            r_nb_sh <= ~b;
            r_c     <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_nb_sh <= {1'b0, r_nb_sh[WIDTH-1:1]};
            r_d_sh  <= w_d_next;
            r_c     <= w_carry;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                // On the MSB bit r_c is the carry into the MSB.
                r_diff <= w_d_next;
                r_cout <= w_carry;
                r_ovf  <= r_c ^ w_carry;
            end
        end
    end

    assign difference = r_diff;
    assign carryout   = r_cout;
    assign overflow   = r_ovf;

endmodule
